// File: rtl/char_term_ctrl.sv
// Terminal write controller for a ROWS x COLS character buffer.
// Handles the byte handshake, cursor tracking, hardware scroll via top_row, and full-screen clear.
module char_term_ctrl #(
  parameter int COLS = 70,
  parameter int ROWS = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_char,
  input  logic        clr,
  output logic [11:0] buf_addr,
  output logic [7:0]  buf_data,
  output logic        buf_we,
  output logic [5:0]  cur_row,
  output logic [6:0]  cur_col,
  output logic [5:0]  top_row,
  output logic        busy
);

  // state  | meaning
  // IDLE   | waiting for a byte or a clear request
  // EXEC   | one cycle; apply the cursor update for the latched byte
  // SCROLL | COLS cycles blanking the recycled row at top_row
  // CLEAR  | ROWS*COLS cycles blanking the whole buffer
  typedef enum logic [1:0] {IDLE, EXEC, SCROLL, CLEAR} state_t;

  localparam logic [11:0] COLS12    = 12'(COLS);
  localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
  localparam logic [5:0]  LAST_ROW  = 6'(ROWS - 1);
  localparam logic [6:0]  ROWS7     = 7'(ROWS);
  localparam logic [11:0] CELLS_M1  = 12'(ROWS * COLS - 1);
  localparam logic [11:0] SCROLL_M1 = 12'(COLS - 1);
  localparam logic [7:0]  BLANK     = 8'h20;

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_char, w_char_nxt;
  logic [5:0]  r_row, w_row_nxt;
  logic [6:0]  r_col, w_col_nxt;
  logic [5:0]  r_top, w_top_nxt;
  logic [11:0] r_cnt, w_cnt_nxt;
  logic [11:0] r_addr, w_addr_nxt;
  logic [7:0]  r_data, w_data_nxt;
  logic        r_we, w_we_nxt;

  logic [6:0]  w_psum;
  logic [5:0]  w_prow;
  logic [11:0] w_row_base;
  logic [11:0] w_top_base;
  logic [11:0] w_cell_addr;
  logic [11:0] w_bs_addr;
  logic        w_in_print;
  logic        w_r_print;
  logic        w_adv;

  assign w_psum      = {1'b0, r_top} + {1'b0, r_row};
  assign w_prow      = (w_psum >= ROWS7) ? 6'(w_psum - ROWS7) : w_psum[5:0];
  assign w_row_base  = {6'b0, w_prow} * COLS12;
  assign w_top_base  = {6'b0, r_top} * COLS12;
  assign w_cell_addr = w_row_base + {5'b0, r_col};
  assign w_bs_addr   = w_row_base + {5'b0, r_col - 7'd1};
  assign w_in_print  = (in_char >= 8'h20) && (in_char <= 8'h7E);
  assign w_r_print   = (r_char >= 8'h20) && (r_char <= 8'h7E);

  assign in_ready = (r_state == IDLE) && !clr;
  assign busy     = (r_state != IDLE);
  assign buf_addr = r_addr;
  assign buf_data = r_data;
  assign buf_we   = r_we;
  assign cur_row  = r_row;
  assign cur_col  = r_col;
  assign top_row  = r_top;

  always_comb begin
    w_state_nxt = r_state;
    w_char_nxt  = r_char;
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;
    w_top_nxt   = r_top;
    w_cnt_nxt   = r_cnt;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_we_nxt    = 1'b0;
    w_adv       = 1'b0;
    case (r_state)
      IDLE: begin
        if (clr) begin
          w_state_nxt = CLEAR;
          w_we_nxt    = 1'b1;
          w_addr_nxt  = 12'd0;
          w_data_nxt  = BLANK;
          w_cnt_nxt   = CELLS_M1;
        end else if (in_valid) begin
          // The write is issued at acceptance so it is visible during EXEC.
          w_state_nxt = EXEC;
          w_char_nxt  = in_char;
          if (w_in_print) begin
            w_we_nxt   = 1'b1;
            w_addr_nxt = w_cell_addr;
            w_data_nxt = in_char;
          end else if (in_char == 8'h08 && r_col != 7'd0) begin
            w_we_nxt   = 1'b1;
            w_addr_nxt = w_bs_addr;
            w_data_nxt = BLANK;
          end
        end
      end
      EXEC: begin
        w_state_nxt = IDLE;
        if (w_r_print) begin
          if (r_col == LAST_COL) begin
            w_col_nxt = 7'd0;
            w_adv     = 1'b1;
          end else begin
            w_col_nxt = r_col + 7'd1;
          end
        end else if (r_char == 8'h0A) begin
          w_col_nxt = 7'd0;
          w_adv     = 1'b1;
        end else if (r_char == 8'h0D) begin
          w_col_nxt = 7'd0;
        end else if (r_char == 8'h08 && r_col != 7'd0) begin
          w_col_nxt = r_col - 7'd1;
        end
        if (w_adv) begin
          if (r_row != LAST_ROW) begin
            w_row_nxt = r_row + 6'd1;
          end else begin
            w_state_nxt = SCROLL;
            w_we_nxt    = 1'b1;
            w_addr_nxt  = w_top_base;
            w_data_nxt  = BLANK;
            w_cnt_nxt   = SCROLL_M1;
          end
        end
      end
      SCROLL: begin
        if (r_cnt == 12'd0) begin
          w_state_nxt = IDLE;
          w_top_nxt   = (r_top == LAST_ROW) ? 6'd0 : r_top + 6'd1;
        end else begin
          w_we_nxt   = 1'b1;
          w_cnt_nxt  = r_cnt - 12'd1;
          w_addr_nxt = r_addr + 12'd1;
        end
      end
      CLEAR: begin
        if (r_cnt == 12'd0) begin
          w_state_nxt = IDLE;
          w_top_nxt   = 6'd0;
          w_row_nxt   = 6'd0;
          w_col_nxt   = 7'd0;
        end else begin
          w_we_nxt   = 1'b1;
          w_cnt_nxt  = r_cnt - 12'd1;
          w_addr_nxt = r_addr + 12'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_char  <= 8'd0;
      r_row   <= 6'd0;
      r_col   <= 7'd0;
      r_top   <= 6'd0;
      r_cnt   <= 12'd0;
      r_addr  <= 12'd0;
      r_data  <= 8'd0;
      r_we    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_char  <= w_char_nxt;
      r_row   <= w_row_nxt;
      r_col   <= w_col_nxt;
      r_top   <= w_top_nxt;
      r_cnt   <= w_cnt_nxt;
      r_addr  <= w_addr_nxt;
      r_data  <= w_data_nxt;
      r_we    <= w_we_nxt;
    end
  end

endmodule

// File: tb/tb_char_term_ctrl.sv
// Bench for char_term_ctrl: a cursor model queues expected buffer writes, and a monitor pops and compares them.
module tb_char_term_ctrl;

  localparam int COLS = 70;
  localparam int ROWS = 30;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_char;
  logic        clr;
  logic [11:0] buf_addr;
  logic [7:0]  buf_data;
  logic        buf_we;
  logic [5:0]  cur_row;
  logic [6:0]  cur_col;
  logic [5:0]  top_row;
  logic        busy;

  char_term_ctrl #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_char(in_char), .clr(clr), .buf_addr(buf_addr), .buf_data(buf_data),
    .buf_we(buf_we), .cur_row(cur_row), .cur_col(cur_col), .top_row(top_row),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;
  int  mrow = 0, mcol = 0, mtop = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_wr(input int a, input int d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic model_adv();
    if (mrow < ROWS - 1) mrow++;
    else begin
      for (int k = 0; k < COLS; k++) push_wr(mtop * COLS + k, 8'h20);
      mtop = (mtop + 1) % ROWS;
    end
  endtask

  task automatic model_byte(input logic [7:0] c);
    int prow;
    prow = (mtop + mrow) % ROWS;
    if (c >= 8'h20 && c <= 8'h7E) begin
      push_wr(prow * COLS + mcol, int'(c));
      mcol++;
      if (mcol == COLS) begin
        mcol = 0;
        model_adv();
      end
    end else if (c == 8'h0A) begin
      mcol = 0;
      model_adv();
    end else if (c == 8'h0D) begin
      mcol = 0;
    end else if (c == 8'h08 && mcol > 0) begin
      mcol--;
      push_wr(prow * COLS + mcol, 8'h20);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && buf_we) begin
      if (exp_q.size() == 0) chk("unexpected_we", 1, 0);
      else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", int'(buf_addr), e.addr);
        chk("wr_data", int'(buf_data), e.data);
      end
    end
  end

  task automatic send(input logic [7:0] c);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) chk("ready_timeout", 1, 0);
    in_valid = 1'b1;
    in_char  = c;
    model_byte(c);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) chk("idle_timeout", 1, 0);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clr = 1'b1;
    for (int a = 0; a < ROWS * COLS; a++) push_wr(a, 8'h20);
    mrow = 0;
    mcol = 0;
    mtop = 0;
    @(posedge clk);
    #1;
    clr = 1'b0;
    wait_idle();
    chk("clr_q_empty", exp_q.size(), 0);
    chk("clr_top", int'(top_row), 0);
    chk("clr_row", int'(cur_row), 0);
    chk("clr_col", int'(cur_col), 0);
  endtask

  task automatic check_cursor(input string tag);
    chk({tag, "_row"}, int'(cur_row), mrow);
    chk({tag, "_col"}, int'(cur_col), mcol);
    chk({tag, "_top"}, int'(top_row), mtop);
    chk({tag, "_q"}, exp_q.size(), 0);
  endtask

  initial begin
    int cnt, ir_bad;
    logic [7:0] txt[$];
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_char  = 8'h00;
    clr      = 1'b1;
    #2;
    chk("rst_ready_clr", int'(in_ready), 0);
    clr = 1'b0;
    #1;
    chk("rst_ready", int'(in_ready), 1);
    chk("rst_we", int'(buf_we), 0);
    chk("rst_addr", int'(buf_addr), 0);
    chk("rst_data", int'(buf_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_row", int'(cur_row), 0);
    chk("rst_col", int'(cur_col), 0);
    chk("rst_top", int'(top_row), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // single printable byte: write visible the cycle after acceptance
    send(8'h41);
    chk("t1_we", int'(buf_we), 1);
    chk("t1_busy", int'(busy), 1);
    chk("t1_ready", int'(in_ready), 0);
    wait_idle();
    chk("t1_col", int'(cur_col), 1);
    chk("t1_ready_idle", int'(in_ready), 1);
    check_cursor("t1");

    do_clear();
    txt = '{8'h48, 8'h69, 8'h0A, 8'h78};
    foreach (txt[i]) send(txt[i]);
    wait_idle();
    chk("t2_row", int'(cur_row), 1);
    chk("t2_col", int'(cur_col), 1);
    check_cursor("t2");

    do_clear();
    send(8'h08);
    wait_idle();
    chk("t3_bs0_col", int'(cur_col), 0);
    txt = '{8'h41, 8'h42, 8'h08, 8'h0D, 8'h07, 8'h43};
    foreach (txt[i]) send(txt[i]);
    wait_idle();
    check_cursor("t3");

    do_clear();
    for (int i = 0; i < COLS; i++) send(8'(8'h30 + i % 40));
    wait_idle();
    chk("t4_row", int'(cur_row), 1);
    chk("t4_col", int'(cur_col), 0);
    send(8'h7E);
    wait_idle();
    check_cursor("t4");

    do_clear();
    for (int i = 0; i < ROWS - 1; i++) send(8'h0A);
    wait_idle();
    chk("t5_row29", int'(cur_row), ROWS - 1);
    send(8'h0A);
    cnt = 0;
    ir_bad = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (!busy) break;
      cnt++;
      if (in_ready) ir_bad++;
    end
    chk("t5_busy_cycles", cnt, 1 + COLS);
    chk("t5_ready_low", ir_bad, 0);
    chk("t5_top", int'(top_row), 1);
    chk("t5_row", int'(cur_row), ROWS - 1);
    send(8'h5A);
    wait_idle();
    check_cursor("t5");
    // printable wrap on the bottom row also scrolls
    for (int i = 0; i < COLS; i++) send(8'h61);
    wait_idle();
    check_cursor("t5w");

    txt = '{8'h54, 8'h65, 8'h0D, 8'h01, 8'h78};
    foreach (txt[i]) send(txt[i]);
    wait_idle();
    do_clear();

    // clear aborted by reset part-way through
    send(8'h51);
    wait_idle();
    @(negedge clk);
    clr = 1'b1;
    for (int a = 0; a < ROWS * COLS; a++) push_wr(a, 8'h20);
    @(posedge clk);
    repeat (500) @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    mrow = 0;
    mcol = 0;
    mtop = 0;
    #1;
    chk("abort_we", int'(buf_we), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_ready_clr", int'(in_ready), 0);
    clr = 1'b0;
    #1;
    chk("abort_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_idle_we", int'(buf_we), 0);
    send(8'h52);
    wait_idle();
    check_cursor("abort");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
